mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: requester ids, the
// in-flight read entry and the cache-line offset width.
package mem_arb_pkg;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  localparam int OFFSET_BITS = 4;

  // Widest address the in-flight entry can carry; WORD_SIZE must not exceed it.
  localparam int INFL_ADDR_W = 64;

  typedef struct packed {
    logic                   vld;
    req_id_e                id;
    logic [INFL_ADDR_W-1:0] addr;
  } infl_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used for the arbiter's capture queues. A push on a full
// queue is accepted only when the same cycle also pops.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: three capture queues, write-first issue, IC/DC read arbitration
// and a fixed-latency response tracker. Define MEM_ARB_FIXED_PRIORITY_EN to make DC reads always beat IC reads.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = 128,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [WORD_SIZE-1:0] ic_req_addr,
  output logic                 ic_res,
  output logic [WORD_SIZE-1:0] ic_res_addr,
  output logic [LINE_SIZE-1:0] ic_res_data,
  input  logic                 dc_req,
  input  logic [WORD_SIZE-1:0] dc_req_addr,
  output logic                 dc_res,
  output logic [WORD_SIZE-1:0] dc_res_addr,
  output logic [LINE_SIZE-1:0] dc_res_data,
  input  logic                 dc_write,
  input  logic [WORD_SIZE-1:0] dc_write_addr,
  input  logic [LINE_SIZE-1:0] dc_write_data,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [LINE_SIZE-1:0] mem_rdata,
  output logic                 err
);
  localparam int WQ_W = WORD_SIZE + LINE_SIZE;
  localparam int QT_W = $clog2(MEM_LATENCY + 1);

  logic                 w_icq_full, w_icq_empty, w_icq_pop;
  logic                 w_dcq_full, w_dcq_empty, w_dcq_pop;
  logic                 w_wq_full, w_wq_empty, w_wq_pop;
  logic [WORD_SIZE-1:0] w_icq_addr, w_dcq_addr, w_rd_addr, w_rd_line;
  logic [WQ_W-1:0]      w_wq_dout;
  logic                 w_issue_wr, w_issue_rd, w_sel_dc;
  logic                 w_drop, w_rsp, w_unexp, w_miss;
  logic                 w_tail_vld;
  req_id_e              w_tail_id;
  logic [WORD_SIZE-1:0] w_tail_addr;
  infl_t                r_infl [MEM_LATENCY];
  logic [QT_W-1:0]      r_quiet;
  logic                 r_err;

  // Capture stage: every request lands in its queue on the cycle it is pulsed
  sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(QUEUE_DEPTH)) u_icq (
    .clk(clk), .rst(rst), .i_push(ic_req), .i_din(ic_req_addr), .i_pop(w_icq_pop),
    .o_dout(w_icq_addr), .o_full(w_icq_full), .o_empty(w_icq_empty));

  sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(QUEUE_DEPTH)) u_dcq (
    .clk(clk), .rst(rst), .i_push(dc_req), .i_din(dc_req_addr), .i_pop(w_dcq_pop),
    .o_dout(w_dcq_addr), .o_full(w_dcq_full), .o_empty(w_dcq_empty));

  sync_fifo #(.WIDTH(WQ_W), .DEPTH(QUEUE_DEPTH)) u_wq (
    .clk(clk), .rst(rst), .i_push(dc_write), .i_din({dc_write_addr, dc_write_data}),
    .i_pop(w_wq_pop), .o_dout(w_wq_dout), .o_full(w_wq_full), .o_empty(w_wq_empty));

  assign w_drop = (ic_req && w_icq_full && !w_icq_pop) ||
                  (dc_req && w_dcq_full && !w_dcq_pop) ||
                  (dc_write && w_wq_full && !w_wq_pop);

  // Issue stage: pending evictions always go first so reads observe them
  assign w_issue_wr = !rst && !w_wq_empty;
  assign w_issue_rd = !rst && w_wq_empty && (!w_icq_empty || !w_dcq_empty);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign w_sel_dc = !w_dcq_empty;
`else
  logic r_rr_dc;
  assign w_sel_dc = !w_dcq_empty && (w_icq_empty || r_rr_dc);

  // After each read the other requester gets the next tie.
  always_ff @(posedge clk) begin
    if (rst)             r_rr_dc <= 1'b1;
    else if (w_issue_rd) r_rr_dc <= !w_sel_dc;
  end
`endif

  assign w_wq_pop  = w_issue_wr;
  assign w_dcq_pop = w_issue_rd && w_sel_dc;
  assign w_icq_pop = w_issue_rd && !w_sel_dc;
  assign w_rd_addr = w_sel_dc ? w_dcq_addr : w_icq_addr;
  assign w_rd_line = {w_rd_addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign mem_valid = w_issue_wr || w_issue_rd;
  assign mem_we    = w_issue_wr;
  assign mem_addr  = w_issue_wr ? w_wq_dout[WQ_W-1:LINE_SIZE] :
                     (w_issue_rd ? w_rd_line : '0);
  assign mem_wdata = w_issue_wr ? w_wq_dout[LINE_SIZE-1:0] : '0;

  // In-flight stage: one slot per cycle of memory latency, reads only
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_infl[i].vld <= 1'b0;
    end else begin
      r_infl[0].vld  <= w_issue_rd;
      r_infl[0].id   <= w_sel_dc ? REQ_DC : REQ_IC;
      r_infl[0].addr <= INFL_ADDR_W'(w_rd_line);
      for (int i = 1; i < MEM_LATENCY; i++) r_infl[i] <= r_infl[i-1];
    end
  end

  assign w_tail_vld  = r_infl[MEM_LATENCY-1].vld;
  assign w_tail_id   = r_infl[MEM_LATENCY-1].id;
  assign w_tail_addr = r_infl[MEM_LATENCY-1].addr[WORD_SIZE-1:0];

  // Response stage: memory data is forwarded in the cycle it arrives
  assign w_rsp       = !rst && w_tail_vld && mem_rvalid;
  assign ic_res      = w_rsp && (w_tail_id == REQ_IC);
  assign dc_res      = w_rsp && (w_tail_id == REQ_DC);
  assign ic_res_addr = ic_res ? w_tail_addr : '0;
  assign dc_res_addr = dc_res ? w_tail_addr : '0;
  assign ic_res_data = ic_res ? mem_rdata : '0;
  assign dc_res_data = dc_res ? mem_rdata : '0;

  // Stray responses right after reset belong to reads that reset discarded.
  assign w_unexp = mem_rvalid && !w_tail_vld && (r_quiet == '0);
  assign w_miss  = w_tail_vld && !mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_quiet <= QT_W'(MEM_LATENCY);
    end else begin
      if (r_quiet != '0) r_quiet <= r_quiet - 1'b1;
      if (w_drop || w_unexp || w_miss) r_err <= 1'b1;
    end
  end

  assign err = r_err && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: queue/in-flight reference model compared
// every cycle, a latency-accurate memory model and directed scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int WS = 32;
  localparam int LS = 128;
  localparam int QD = 4;
  localparam int LAT = 5;

  logic          clk = 1'b0, rst = 1'b1;
  logic          ic_req = 0, dc_req = 0, dc_write = 0;
  logic [WS-1:0] ic_req_addr = 0, dc_req_addr = 0, dc_write_addr = 0;
  logic [LS-1:0] dc_write_data = 0;
  logic          ic_res, dc_res, mem_valid, mem_we, err;
  logic [WS-1:0] ic_res_addr, dc_res_addr, mem_addr;
  logic [LS-1:0] ic_res_data, dc_res_data, mem_wdata;
  logic          mem_rvalid = 0, inj_rvalid = 0;
  logic [LS-1:0] mem_rdata = 0;

  int checks = 0, errors = 0, cyc = 0;

  mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .QUEUE_DEPTH(QD), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_req_addr(ic_req_addr), .ic_res(ic_res), .ic_res_addr(ic_res_addr),
    .ic_res_data(ic_res_data),
    .dc_req(dc_req), .dc_req_addr(dc_req_addr), .dc_res(dc_res), .dc_res_addr(dc_res_addr),
    .dc_res_data(dc_res_data),
    .dc_write(dc_write), .dc_write_addr(dc_write_addr), .dc_write_data(dc_write_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model storage and pending responses
  typedef struct { int due; logic [LS-1:0] data; } pend_t;
  logic [LS-1:0] mem_m [logic [WS-1:0]];
  pend_t         pend[$];

  // Observation logs keyed by cycle, used by the directed checks
  logic [WS-1:0] iss_addr [int];
  logic          iss_we [int];
  logic [LS-1:0] iss_wdata [int];
  logic          rsp_dc [int];
  logic [WS-1:0] rsp_addr [int];
  logic [LS-1:0] rsp_data [int];
  bit            rv_seen [int];

  // Reference model state
  typedef struct { int due; bit dc; logic [WS-1:0] addr; } infl_m_t;
  logic [WS-1:0]    m_icq[$], m_dcq[$];
  logic [WS+LS-1:0] m_wq[$];
  infl_m_t          m_infl[$];
  bit               m_err = 0, m_fav_dc = 1;
  int               m_quiet = 0;

  function automatic logic [LS-1:0] pat(input logic [WS-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h1234_5678};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic          e_v = 0, e_we = 0, e_icr = 0, e_dcr = 0;
    logic [WS-1:0] e_addr = 0, e_icra = 0, e_dcra = 0;
    logic [LS-1:0] e_wd = 0, e_icrd = 0, e_dcrd = 0;
    bit            pop_w = 0, pop_ic = 0, pop_dc = 0, rd_dc = 0;
    int            hit = -1;
    if (!rst) begin
      if (m_wq.size() > 0) begin
        e_v = 1; e_we = 1; e_addr = m_wq[0][WS+LS-1:LS]; e_wd = m_wq[0][LS-1:0]; pop_w = 1;
      end else if (m_icq.size() > 0 || m_dcq.size() > 0) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        rd_dc = (m_dcq.size() > 0);
`else
        rd_dc = (m_dcq.size() > 0) && (m_icq.size() == 0 || m_fav_dc);
`endif
        e_v = 1;
        e_addr = (rd_dc ? m_dcq[0] : m_icq[0]) & ~32'hF;
        pop_dc = rd_dc; pop_ic = !rd_dc;
      end
      foreach (m_infl[i]) if (m_infl[i].due == cyc) hit = i;
      if (hit >= 0 && mem_rvalid) begin
        if (m_infl[hit].dc) begin e_dcr = 1; e_dcra = m_infl[hit].addr; e_dcrd = mem_rdata; end
        else begin e_icr = 1; e_icra = m_infl[hit].addr; e_icrd = mem_rdata; end
      end
    end
    chk("mem_valid", 160'(mem_valid), 160'(e_v));
    chk("mem_we", 160'(mem_we), 160'(e_we));
    chk("mem_addr", 160'(mem_addr), 160'(e_addr));
    chk("mem_wdata", 160'(mem_wdata), 160'(e_wd));
    chk("ic_res", 160'(ic_res), 160'(e_icr));
    chk("ic_res_addr", 160'(ic_res_addr), 160'(e_icra));
    chk("ic_res_data", 160'(ic_res_data), 160'(e_icrd));
    chk("dc_res", 160'(dc_res), 160'(e_dcr));
    chk("dc_res_addr", 160'(dc_res_addr), 160'(e_dcra));
    chk("dc_res_data", 160'(dc_res_data), 160'(e_dcrd));
    chk("err", 160'(err), 160'(rst ? 1'b0 : m_err));
    if (rst) begin
      m_icq.delete(); m_dcq.delete(); m_wq.delete(); m_infl.delete();
      m_err = 0; m_fav_dc = 1; m_quiet = LAT;
      return;
    end
    if (hit >= 0) begin
      if (!mem_rvalid) m_err = 1;
      m_infl.delete(hit);
    end else if (mem_rvalid && m_quiet == 0) m_err = 1;
    if (m_quiet > 0) m_quiet--;
    if (pop_w) void'(m_wq.pop_front());
    if (pop_ic) begin void'(m_icq.pop_front()); m_infl.push_back('{cyc + LAT, 1'b0, e_addr}); m_fav_dc = 1; end
    if (pop_dc) begin void'(m_dcq.pop_front()); m_infl.push_back('{cyc + LAT, 1'b1, e_addr}); m_fav_dc = 0; end
    if (ic_req) begin if (m_icq.size() < QD) m_icq.push_back(ic_req_addr); else m_err = 1; end
    if (dc_req) begin if (m_dcq.size() < QD) m_dcq.push_back(dc_req_addr); else m_err = 1; end
    if (dc_write) begin
      if (m_wq.size() < QD) m_wq.push_back({dc_write_addr, dc_write_data}); else m_err = 1;
    end
  endtask

  always @(negedge clk) begin
    model_step();
    if (mem_valid) begin
      iss_addr[cyc] = mem_addr; iss_we[cyc] = mem_we; iss_wdata[cyc] = mem_wdata;
      if (mem_we) mem_m[mem_addr] = mem_wdata;
      else pend.push_back('{cyc + LAT, mem_m.exists(mem_addr) ? mem_m[mem_addr] : pat(mem_addr)});
    end
    if (ic_res) begin rsp_dc[cyc] = 0; rsp_addr[cyc] = ic_res_addr; rsp_data[cyc] = ic_res_data; end
    if (dc_res) begin rsp_dc[cyc] = 1; rsp_addr[cyc] = dc_res_addr; rsp_data[cyc] = dc_res_data; end
    if (mem_rvalid) rv_seen[cyc] = 1;
  end

  always @(posedge clk) begin
    #2;
    mem_rvalid = inj_rvalid;
    mem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
      void'(pend.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    ic_req = 0; dc_req = 0; dc_write = 0; inj_rvalid = 0;
  endtask

  task automatic chk_issue(input string name, input int c, input logic we, input logic [WS-1:0] a);
    logic [WS-1:0] ga = iss_addr.exists(c) ? iss_addr[c] : 32'hFFFF_FFFF;
    logic          gw = iss_we.exists(c) ? iss_we[c] : 1'bx;
    chk({name, "_addr"}, 160'(ga), 160'(a));
    chk({name, "_we"}, 160'(gw), 160'(we));
  endtask

  task automatic chk_rsp(input string name, input int c, input logic dc, input logic [WS-1:0] a,
                         input logic [LS-1:0] d);
    chk({name, "_seen"}, 160'(rsp_addr.exists(c)), 160'(1));
    if (rsp_addr.exists(c)) begin
      chk({name, "_id"}, 160'(rsp_dc[c]), 160'(dc));
      chk({name, "_addr"}, 160'(rsp_addr[c]), 160'(a));
      chk({name, "_data"}, 160'(rsp_data[c]), 160'(d));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int t, n;
    logic [WS-1:0] exp_ord [6];
    logic [LS-1:0] d_b;
    d_b = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    chk("reset_err", 160'(err), 160'(0));
    chk("reset_mem_valid", 160'(mem_valid), 160'(0));

    // Simultaneous IC and DC reads: DC first from reset pointer
    t = cyc; ic_req = 1; ic_req_addr = 32'h100; dc_req = 1; dc_req_addr = 32'h200;
    tick(); repeat (9) tick();
    chk_issue("A_dc_issue", t + 1, 0, 32'h200);
    chk_issue("A_ic_issue", t + 2, 0, 32'h100);
    chk_rsp("A_dc_res", t + 6, 1, 32'h200, pat(32'h200));
    chk_rsp("A_ic_res", t + 7, 0, 32'h100, pat(32'h100));

    // Offset bits are cleared on the memory address
    t = cyc; ic_req = 1; ic_req_addr = 32'h10C;
    tick(); repeat (7) tick();
    chk_issue("A2_issue", t + 1, 0, 32'h100);
    chk_rsp("A2_res", t + 6, 0, 32'h100, pat(32'h100));

    // Eviction and read of the same line in one cycle
    t = cyc; dc_write = 1; dc_write_addr = 32'h300; dc_write_data = d_b; dc_req = 1; dc_req_addr = 32'h300;
    tick(); repeat (9) tick();
    chk_issue("B_wr_issue", t + 1, 1, 32'h300);
    chk("B_wr_data", 160'(iss_wdata.exists(t + 1) ? iss_wdata[t + 1] : '0), 160'(d_b));
    chk_issue("B_rd_issue", t + 2, 0, 32'h300);
    chk_rsp("B_res", t + 7, 1, 32'h300, d_b);

    // Five IC requests while writes hold the bus: fifth dropped
    t = cyc;
    for (int i = 0; i < 5; i++) begin
      dc_write = 1; dc_write_addr = 32'h2000 + 32'(i * 16); dc_write_data = 128'(i);
      ic_req = 1; ic_req_addr = 32'h1000 + 32'(i * 16);
      tick();
    end
    chk("C_err_set", 160'(err), 160'(1));
    repeat (12) tick();
    chk_issue("C_ic0", t + 6, 0, 32'h1000);
    chk_issue("C_ic3", t + 9, 0, 32'h1030);
    chk("C_no_fifth", 160'(iss_addr.exists(t + 10)), 160'(0));
    chk("C_err_sticky", 160'(err), 160'(1));
    rst = 1; tick(); rst = 0;
    chk("C_err_cleared", 160'(err), 160'(0));

    // Reset two cycles after a read issue
    t = cyc; ic_req = 1; ic_req_addr = 32'h400;
    tick(); tick(); tick();
    rst = 1; tick(); rst = 0;
    repeat (8) tick();
    n = 0;
    for (int c = t + 1; c <= t + 12; c++) if (rsp_addr.exists(c)) n++;
    chk("D_no_res", 160'(n), 160'(0));
    chk("D_late_rvalid_seen", 160'(rv_seen.exists(t + 6)), 160'(1));
    chk("D_err_clear", 160'(err), 160'(0));

    // Unsolicited memory response
    t = cyc; inj_rvalid = 1;
    tick();
    chk("E_err", 160'(err), 160'(1));
    chk("E_no_res", 160'(rsp_addr.exists(t)), 160'(0));
    rst = 1; tick(); rst = 0;

    // Three IC and three DC reads queued behind writes
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      ic_req = 1; ic_req_addr = 32'h500 + 32'(i * 16);
      dc_req = 1; dc_req_addr = 32'h600 + 32'(i * 16);
      dc_write = 1; dc_write_addr = 32'h700 + 32'(i * 16); dc_write_data = 128'(i + 7);
      tick();
    end
    repeat (14) tick();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp_ord = '{32'h600, 32'h610, 32'h620, 32'h500, 32'h510, 32'h520};
`else
    exp_ord = '{32'h600, 32'h500, 32'h610, 32'h510, 32'h620, 32'h520};
`endif
    for (int i = 0; i < 6; i++) chk_issue($sformatf("F_rd%0d", i), t + 4 + i, 0, exp_ord[i]);

    // Push into a full IC queue in the cycle it pops: accepted, no error
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      dc_write = 1; dc_write_addr = 32'h780 + 32'(i * 16); dc_write_data = 128'(i);
      ic_req = 1; ic_req_addr = 32'h900 + 32'(i * 16);
      tick();
    end
    tick();
    ic_req = 1; ic_req_addr = 32'h940;
    tick();
    chk("G_err_clear", 160'(err), 160'(0));
    repeat (12) tick();
    chk_issue("G_ic0", t + 5, 0, 32'h900);
    chk_issue("G_ic4", t + 9, 0, 32'h940);

    // Same address from both caches: two independent reads
    t = cyc; ic_req = 1; ic_req_addr = 32'h800; dc_req = 1; dc_req_addr = 32'h800;
    tick(); repeat (9) tick();
    chk_rsp("H_dc_res", t + 6, 1, 32'h800, pat(32'h800));
    chk_rsp("H_ic_res", t + 7, 0, 32'h800, pat(32'h800));
    chk("H_err", 160'(err), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
